freelist_ctrl: RTL and testbench

FREELIST_CTRL -- requirements
Module: freelist_ctrl

---
 rtl/freelist_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_freelist_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freelist_ctrl.sv
// -----------------------------------------------------------------------------
// freelist_ctrl -- physical register free list for a two-wide rename stage.
//
// Free physical tags live in a D = NUM_PHY-NUM_ARCH entry circular buffer.
// Allocation reads from head and release writes at tail. Each pointer carries a
// wrap bit above its index bits, so a full list and an empty list can be told
// apart.
//
// Optional feature (macro FREELIST_RECOVERY_EN):
//   Adds input com_alloc_cnt and a commit_head pointer. On prmiss, head is
//   rewound to the committed position, which returns every speculative
//   allocation to the list. Without the macro, prmiss only blocks grants.
//
// Ports:
//   clk                           clock
//   reset_x                       asynchronous active-low reset
//   req_1, req_2                  rename slot 1/2 needs a destination tag
//   phy_dst_1, phy_dst_2          allocated tags, valid in the request cycle
//   phy_dst_valid_1/2             tag granted to slot 1/2
//   stall                         a requested allocation was refused
//   rel_1, rel_2                  commit frees a tag
//   rel_tag_1, rel_tag_2          tags being freed
//   prmiss                        branch mispredict flush
//   com_alloc_cnt                 (FREELIST_RECOVERY_EN) committed allocations, 0..2
//   free_cnt                      number of free entries
//   ovf_err                       sticky flag: a release overflowed the list
// -----------------------------------------------------------------------------
`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif

module freelist_ctrl #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHY  = 64
) (
  input  logic                    clk,
  input  logic                    reset_x,
  input  logic                    req_1,
  input  logic                    req_2,
  output logic [`PHY_REG_SEL-1:0] phy_dst_1,
  output logic [`PHY_REG_SEL-1:0] phy_dst_2,
  output logic                    phy_dst_valid_1,
  output logic                    phy_dst_valid_2,
  output logic                    stall,
  input  logic                    rel_1,
  input  logic                    rel_2,
  input  logic [`PHY_REG_SEL-1:0] rel_tag_1,
  input  logic [`PHY_REG_SEL-1:0] rel_tag_2,
  input  logic                    prmiss,
`ifdef FREELIST_RECOVERY_EN
  input  logic [1:0]              com_alloc_cnt,
`endif
  output logic [`PHY_REG_SEL-1:0] free_cnt,
  output logic                    ovf_err
);

  localparam int D  = NUM_PHY - NUM_ARCH;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = IW + 1;

  typedef logic [`PHY_REG_SEL-1:0] tag_t;
  typedef logic [IW-1:0]           idx_t;
  typedef logic [CW-1:0]           cnt_t;
  typedef struct packed {
    logic wrap;
    idx_t idx;
  } ptr_t;

  // Next index modulo D; used for the second slot of a dual access.
  function automatic idx_t idx_inc1(input idx_t i);
    return (i == idx_t'(D - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // Advance a pointer by 0..3 entries. The index wraps modulo D, and the wrap
  // bit toggles when the index passes D-1.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    cnt_t sum;
    ptr_t r;
    sum = cnt_t'(p.idx) + cnt_t'(n);
    if (sum >= cnt_t'(D)) begin
      r.wrap = ~p.wrap;
      r.idx  = idx_t'(sum - cnt_t'(D));
    end else begin
      r.wrap = p.wrap;
      r.idx  = idx_t'(sum);
    end
    return r;
  endfunction

  tag_t       list [D];
  ptr_t       head;
  ptr_t       tail;
  ptr_t       head_nxt;
  ptr_t       tail_nxt;
  cnt_t       cnt;
  logic [1:0] n_req;
  logic       grant;
  logic       acc_1;
  logic       acc_2;
  logic       ovf_set;
  idx_t       wr_idx_2;

`ifdef FREELIST_RECOVERY_EN
  ptr_t       commit_head;
  ptr_t       commit_nxt;
`endif

  // Occupancy from the pointer pair. When the wrap bits differ, tail is one
  // lap ahead of head.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    cnt = '0;
    if (head.wrap == tail.wrap) cnt = cnt_t'(tail.idx) - cnt_t'(head.idx);
    else                        cnt = cnt_t'(D) - cnt_t'(head.idx) + cnt_t'(tail.idx);
  end

  always_comb begin
    n_req    = {1'b0, req_1} + {1'b0, req_2};
    // All-or-nothing. A same-cycle release cannot help, because cnt only
    // reflects state that was already registered.
    grant    = reset_x & ~prmiss & (cnt_t'(n_req) <= cnt);
    // A release is accepted only while the list has room. When both releases
    // arrive and only one fits, rel_1 takes the last slot.
    acc_1    = rel_1 & (cnt < cnt_t'(D));
    acc_2    = rel_2 & ((cnt + cnt_t'(acc_1)) < cnt_t'(D));
    ovf_set  = (rel_1 & ~acc_1) | (rel_2 & ~acc_2);
    wr_idx_2 = acc_1 ? idx_inc1(tail.idx) : tail.idx;
    tail_nxt = ptr_add(tail, {1'b0, acc_1} + {1'b0, acc_2});
    head_nxt = grant ? ptr_add(head, n_req) : head;
`ifdef FREELIST_RECOVERY_EN
    commit_nxt = ptr_add(commit_head, com_alloc_cnt);
    // Rewinding head to the committed point returns speculative allocations.
    if (prmiss) head_nxt = commit_nxt;
`endif
  end

  assign phy_dst_valid_1 = req_1 & grant;
  assign phy_dst_valid_2 = req_2 & grant;
  assign stall           = reset_x & (n_req != 2'd0) & ~grant;
  assign free_cnt        = tag_t'(cnt);

  // Slot 2 takes the second free entry only when slot 1 also allocates. In
  // reset it shows list[head+1] so that both outputs present the first two tags.
  assign phy_dst_1 = list[head.idx];
  assign phy_dst_2 = (req_1 | ~reset_x) ? list[idx_inc1(head.idx)] : list[head.idx];

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      head    <= '0;
      tail    <= ptr_t'{wrap: 1'b1, idx: '0};
      ovf_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge, whatever the statement order.
      head <= head_nxt;
      tail <= tail_nxt;
      if (ovf_set) ovf_err <= 1'b1;
    end
  end

`ifdef FREELIST_RECOVERY_EN
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) commit_head <= '0;
    else          commit_head <= commit_nxt;
  end
`endif

  // NOTE: this storage is reset on purpose. At power-up the list must already
  // hold tags NUM_ARCH..NUM_PHY-1, so it is built from resettable flops
  // rather than an SRAM macro.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      for (int i = 0; i < D; i++) list[i] <= tag_t'(NUM_ARCH + i);
    end else begin
      if (acc_1) list[tail.idx] <= rel_tag_1;
      if (acc_2) list[wr_idx_2] <= rel_tag_2;
    end
  end

endmodule

// File: tb/tb_freelist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freelist_ctrl -- self-checking bench for freelist_ctrl.
// Directed scenarios cover reset, single and dual grants, stall with release,
// wrap/overflow and reset during operation. A randomized run is scored against
// a queue model of the free list: allocation pops from the front and release
// pushes to the back.
// -----------------------------------------------------------------------------
module tb_freelist_ctrl;

  localparam int D  = 32;
  localparam int NA = 32;

  logic       clk = 1'b0;
  logic       reset_x = 1'b0;
  logic       req_1 = 1'b0, req_2 = 1'b0;
  logic [5:0] phy_dst_1, phy_dst_2;
  logic       phy_dst_valid_1, phy_dst_valid_2;
  logic       stall;
  logic       rel_1 = 1'b0, rel_2 = 1'b0;
  logic [5:0] rel_tag_1 = '0, rel_tag_2 = '0;
  logic       prmiss = 1'b0;
  logic [5:0] free_cnt;
  logic       ovf_err;
`ifdef FREELIST_RECOVERY_EN
  logic [1:0] com_alloc_cnt = 2'd0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int   q[$];     // free tags in allocation order
  int   held[$];  // tags allocated and not yet released
  logic m_ovf;

  freelist_ctrl #(.NUM_ARCH(32), .NUM_PHY(64)) dut (
    .clk             (clk),
    .reset_x         (reset_x),
    .req_1           (req_1),
    .req_2           (req_2),
    .phy_dst_1       (phy_dst_1),
    .phy_dst_2       (phy_dst_2),
    .phy_dst_valid_1 (phy_dst_valid_1),
    .phy_dst_valid_2 (phy_dst_valid_2),
    .stall           (stall),
    .rel_1           (rel_1),
    .rel_2           (rel_2),
    .rel_tag_1       (rel_tag_1),
    .rel_tag_2       (rel_tag_2),
    .prmiss          (prmiss),
`ifdef FREELIST_RECOVERY_EN
    .com_alloc_cnt   (com_alloc_cnt),
`endif
    .free_cnt        (free_cnt),
    .ovf_err         (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r1, input logic r2, input logic pm,
                        input logic l1, input logic [5:0] t1,
                        input logic l2, input logic [5:0] t2);
    req_1 = r1; req_2 = r2; prmiss = pm;
    rel_1 = l1; rel_tag_1 = t1; rel_2 = l2; rel_tag_2 = t2;
  endtask

  task automatic model_reset();
    q.delete();
    held.delete();
    for (int i = 0; i < D; i++) q.push_back(NA + i);
    m_ovf = 1'b0;
  endtask

  // Apply the current bench inputs to the model as one clock edge.
  task automatic model_step();
    int n, fc;
    n  = int'(req_1) + int'(req_2);
    fc = q.size();
    if (!prmiss && n <= fc) repeat (n) held.push_back(q.pop_front());
    if (rel_1) begin
      if (fc < D) begin q.push_back(int'(rel_tag_1)); fc++; end else m_ovf = 1'b1;
    end
    if (rel_2) begin
      if (fc < D) begin q.push_back(int'(rel_tag_2)); fc++; end else m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
`ifdef FREELIST_RECOVERY_EN
    com_alloc_cnt = 2'd0;
`endif
    reset_x = 1'b0;
    repeat (2) tick();
    reset_x = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    reset_x = 1'b0;
    tick();
    checks++; if (phy_dst_valid_1 !== 1'b0) begin failures++; $display("FAIL reset_v1 got=%0b exp=0", phy_dst_valid_1); end
    checks++; if (phy_dst_valid_2 !== 1'b0) begin failures++; $display("FAIL reset_v2 got=%0b exp=0", phy_dst_valid_2); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (phy_dst_1 !== 6'd32) begin failures++; $display("FAIL reset_dst1 got=%0d exp=32", phy_dst_1); end
    checks++; if (phy_dst_2 !== 6'd33) begin failures++; $display("FAIL reset_dst2 got=%0d exp=33", phy_dst_2); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL reset_free got=%0d exp=32", free_cnt); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf_err); end
    do_reset();
  endtask

  task automatic test_dual_alloc();
    do_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (phy_dst_1 !== 6'd32) begin failures++; $display("FAIL dual_dst1 got=%0d exp=32", phy_dst_1); end
    checks++; if (phy_dst_2 !== 6'd33) begin failures++; $display("FAIL dual_dst2 got=%0d exp=33", phy_dst_2); end
    checks++; if ({phy_dst_valid_1, phy_dst_valid_2} !== 2'b11) begin failures++; $display("FAIL dual_valid got=%b exp=11", {phy_dst_valid_1, phy_dst_valid_2}); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dual_stall got=%0b exp=0", stall); end
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd30) begin failures++; $display("FAIL dual_free got=%0d exp=30", free_cnt); end
  endtask

  task automatic test_slot2_only();
    do_reset();
    set_in(0, 1, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (phy_dst_2 !== 6'd32) begin failures++; $display("FAIL slot2_dst2 got=%0d exp=32", phy_dst_2); end
    checks++; if ({phy_dst_valid_1, phy_dst_valid_2} !== 2'b01) begin failures++; $display("FAIL slot2_valid got=%b exp=01", {phy_dst_valid_1, phy_dst_valid_2}); end
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd31) begin failures++; $display("FAIL slot2_free got=%0d exp=31", free_cnt); end
  endtask

  task automatic test_stall_release();
    do_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    repeat (15) tick();
    set_in(1, 0, 0, 0, 6'd0, 0, 6'd0);
    tick();
    set_in(1, 1, 0, 1, 6'd5, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd1) begin failures++; $display("FAIL stall_free_before got=%0d exp=1", free_cnt); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_flag got=%0b exp=1", stall); end
    checks++; if ({phy_dst_valid_1, phy_dst_valid_2} !== 2'b00) begin failures++; $display("FAIL stall_valid got=%b exp=00", {phy_dst_valid_1, phy_dst_valid_2}); end
    tick();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd2) begin failures++; $display("FAIL stall_free_after got=%0d exp=2", free_cnt); end
    checks++; if ({phy_dst_valid_1, phy_dst_valid_2, stall} !== 3'b110) begin failures++; $display("FAIL stall_regrant got=%b exp=110", {phy_dst_valid_1, phy_dst_valid_2, stall}); end
    checks++; if (phy_dst_1 !== 6'd63) begin failures++; $display("FAIL stall_dst1 got=%0d exp=63", phy_dst_1); end
    checks++; if (phy_dst_2 !== 6'd5) begin failures++; $display("FAIL stall_dst2 got=%0d exp=5", phy_dst_2); end
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
  endtask

  task automatic test_wrap_ovf();
    do_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    repeat (16) tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd0) begin failures++; $display("FAIL wrap_empty got=%0d exp=0", free_cnt); end
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 0, 1, 6'(2 * i), 1, 6'(2 * i + 1));
      tick();
    end
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL wrap_full got=%0d exp=32", free_cnt); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL wrap_ovf_pre got=%0b exp=0", ovf_err); end
    set_in(0, 0, 0, 1, 6'd7, 0, 6'd0);
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL wrap_ovf_set got=%0b exp=1", ovf_err); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL wrap_ovf_free got=%0d exp=32", free_cnt); end
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
      #1;
      checks++; if (phy_dst_1 !== 6'(2 * i) || phy_dst_valid_1 !== 1'b1) begin failures++; $display("FAIL wrap_order1 i=%0d got=%0d exp=%0d", i, phy_dst_1, 2 * i); end
      checks++; if (phy_dst_2 !== 6'(2 * i + 1) || phy_dst_valid_2 !== 1'b1) begin failures++; $display("FAIL wrap_order2 i=%0d got=%0d exp=%0d", i, phy_dst_2, 2 * i + 1); end
      tick();
    end
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd0) begin failures++; $display("FAIL wrap_drained got=%0d exp=0", free_cnt); end
    checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL wrap_ovf_sticky got=%0b exp=1", ovf_err); end
  endtask

  task automatic test_prmiss();
    do_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    tick();
`ifdef FREELIST_RECOVERY_EN
    set_in(1, 1, 1, 0, 6'd0, 0, 6'd0);
`else
    set_in(1, 1, 1, 1, 6'd32, 0, 6'd0);
`endif
    #1;
    checks++; if ({phy_dst_valid_1, phy_dst_valid_2, stall} !== 3'b001) begin failures++; $display("FAIL prmiss_block got=%b exp=001", {phy_dst_valid_1, phy_dst_valid_2, stall}); end
    tick();
    set_in(1, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
`ifdef FREELIST_RECOVERY_EN
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL prmiss_free got=%0d exp=32", free_cnt); end
    checks++; if (phy_dst_1 !== 6'd32) begin failures++; $display("FAIL prmiss_next got=%0d exp=32", phy_dst_1); end
`else
    checks++; if (free_cnt !== 6'd31) begin failures++; $display("FAIL prmiss_free got=%0d exp=31", free_cnt); end
    checks++; if (phy_dst_1 !== 6'd34) begin failures++; $display("FAIL prmiss_next got=%0d exp=34", phy_dst_1); end
`endif
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
  endtask

`ifdef FREELIST_RECOVERY_EN
  task automatic test_recovery();
    do_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    repeat (3) tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    com_alloc_cnt = 2'd2;
    tick();
    com_alloc_cnt = 2'd0;
    prmiss = 1'b1;
    tick();
    set_in(1, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (free_cnt !== 6'd30) begin failures++; $display("FAIL recov_free got=%0d exp=30", free_cnt); end
    checks++; if (phy_dst_1 !== 6'd34 || phy_dst_valid_1 !== 1'b1) begin failures++; $display("FAIL recov_tag got=%0d exp=34", phy_dst_1); end
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
  endtask
`endif

  task automatic test_random();
    int   n, idx, t1, t2, e_d2;
    logic r1, r2, pm, l1, l2, e_g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
`ifdef FREELIST_RECOVERY_EN
      pm = 1'b0;
`else
      pm = ($urandom_range(0, 7) == 0);
`endif
      l1 = 1'b0; t1 = 0; l2 = 1'b0; t2 = 0;
      if (held.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, held.size() - 1)); t1 = held[idx]; held.delete(idx); l1 = 1'b1;
      end
      if (held.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, held.size() - 1)); t2 = held[idx]; held.delete(idx); l2 = 1'b1;
      end
      set_in(r1, r2, pm, l1, 6'(t1), l2, 6'(t2));
      #1;
      n   = int'(r1) + int'(r2);
      e_g = !pm && (n <= q.size());
      checks++; if (phy_dst_valid_1 !== (r1 & e_g)) begin failures++; $display("FAIL rnd_v1 c=%0d got=%0b exp=%0b", c, phy_dst_valid_1, r1 & e_g); end
      checks++; if (phy_dst_valid_2 !== (r2 & e_g)) begin failures++; $display("FAIL rnd_v2 c=%0d got=%0b exp=%0b", c, phy_dst_valid_2, r2 & e_g); end
      checks++; if (stall !== ((n != 0) && !e_g)) begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, stall, (n != 0) && !e_g); end
      checks++; if (int'(free_cnt) != q.size()) begin failures++; $display("FAIL rnd_free c=%0d got=%0d exp=%0d", c, free_cnt, q.size()); end
      if (e_g && r1) begin
        checks++; if (int'(phy_dst_1) != q[0]) begin failures++; $display("FAIL rnd_dst1 c=%0d got=%0d exp=%0d", c, phy_dst_1, q[0]); end
      end
      if (e_g && r2) begin
        e_d2 = r1 ? q[1] : q[0];
        checks++; if (int'(phy_dst_2) != e_d2) begin failures++; $display("FAIL rnd_dst2 c=%0d got=%0d exp=%0d", c, phy_dst_2, e_d2); end
      end
      model_step();
      tick();
    end
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    #1;
    checks++; if (ovf_err !== m_ovf) begin failures++; $display("FAIL rnd_ovf got=%0b exp=%0b", ovf_err, m_ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1, 1, 0, 0, 6'd0, 0, 6'd0);
    repeat (3) tick();
    #1;
    checks++; if (phy_dst_1 !== 6'd38 || phy_dst_valid_1 !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d exp=38", phy_dst_1); end
    reset_x = 1'b0;
    #1;
    checks++; if ({phy_dst_valid_1, phy_dst_valid_2, stall} !== 3'b000) begin failures++; $display("FAIL mid_ctrl got=%b exp=000", {phy_dst_valid_1, phy_dst_valid_2, stall}); end
    checks++; if (phy_dst_1 !== 6'd32 || phy_dst_2 !== 6'd33) begin failures++; $display("FAIL mid_dst got=%0d,%0d exp=32,33", phy_dst_1, phy_dst_2); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL mid_free got=%0d exp=32", free_cnt); end
    tick();
    set_in(0, 0, 0, 0, 6'd0, 0, 6'd0);
    reset_x = 1'b1;
    tick();
    checks++; if (free_cnt !== 6'd32 || ovf_err !== 1'b0) begin failures++; $display("FAIL mid_after got=%0d/%0b exp=32/0", free_cnt, ovf_err); end
    checks++; if (phy_dst_1 !== 6'd32) begin failures++; $display("FAIL mid_after_dst got=%0d exp=32", phy_dst_1); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dual_alloc();
    test_slot2_only();
    test_stall_release();
    test_wrap_ovf();
    test_prmiss();
`ifdef FREELIST_RECOVERY_EN
    test_recovery();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
